// File: rtl/uart_tx_word_feeder_pkg.sv
// Shared definitions for the word-to-byte UART feeder: sequencer states and word geometry.
package uart_tx_word_feeder_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_word_feeder_sync_fifo.sv
// Single-clock FIFO with combinational head read; pushes while full and pops while empty are ignored.
module sync_fifo
    import uart_tx_word_feeder_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Push,
    input  logic [WIDTH-1:0]  i_Push_Data,
    input  logic              i_Pop,
    output logic [WIDTH-1:0]  o_Pop_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  r_Mem [DEPTH];
    logic [ADDR_W-1:0] r_Wr_Ptr;
    logic [ADDR_W-1:0] r_Rd_Ptr;
    logic [ADDR_W:0]   r_Count;
    logic              w_Push_Ok;
    logic              w_Pop_Ok;

    assign w_Push_Ok = i_Push && (r_Count != FULL_CNT);
    assign w_Pop_Ok  = i_Pop && (r_Count != '0);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
        end else begin
            if (w_Push_Ok) r_Wr_Ptr <= r_Wr_Ptr + ADDR_W'(1);
            if (w_Pop_Ok)  r_Rd_Ptr <= r_Rd_Ptr + ADDR_W'(1);
            case ({w_Push_Ok, w_Pop_Ok})
                2'b10:   r_Count <= r_Count + (ADDR_W+1)'(1);
                2'b01:   r_Count <= r_Count - (ADDR_W+1)'(1);
                default: r_Count <= r_Count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge i_Clock) begin
        if (w_Push_Ok) r_Mem[r_Wr_Ptr] <= i_Push_Data;
    end

    assign o_Pop_Data = r_Mem[r_Rd_Ptr];
    assign o_Full     = (r_Count == FULL_CNT);
    assign o_Empty    = (r_Count == '0);
    assign o_Count    = r_Count;

endmodule

// File: rtl/uart_tx_word_feeder.sv
// Buffers 32-bit words and feeds them byte by byte to a UART transmitter via DV pulse / done handshake.
module uart_tx_word_feeder
    import uart_tx_word_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Word_DV,
    input  logic [31:0]       i_Word,
    output logic              o_Word_Ready,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy,
    output logic [ADDR_W:0]   o_Fifo_Count
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    feeder_state_t         r_State;
    feeder_state_t         w_Next_State;
    logic                  r_Done_Q;
    logic                  w_Done_Rise;
    logic [WORD_W-1:0]     r_Shift;
    logic [WORD_W-1:0]     w_Shift_Next;
    logic [BYTE_IDX_W-1:0] r_Byte_Idx;
    logic                  w_Pop;
    logic                  w_Shift_En;
    logic                  w_Fifo_Full;
    logic                  w_Fifo_Empty;
    logic [WORD_W-1:0]     w_Head;
    logic [ADDR_W:0]       w_Count;

    sync_fifo #(
        .WIDTH  (WORD_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Push      (i_Word_DV),
        .i_Push_Data (i_Word),
        .i_Pop       (w_Pop),
        .o_Pop_Data  (w_Head),
        .o_Full      (w_Fifo_Full),
        .o_Empty     (w_Fifo_Empty),
        .o_Count     (w_Count)
    );

    assign w_Done_Rise = i_Tx_Done && !r_Done_Q;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) r_State <= ST_IDLE;
        else            r_State <= w_Next_State;
    end

    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            ST_IDLE:      if (!w_Fifo_Empty && !i_Tx_Active) w_Next_State = ST_LOAD;
            ST_LOAD:      w_Next_State = ST_ISSUE;
            ST_ISSUE:     w_Next_State = ST_WAIT_DONE;
            ST_WAIT_DONE: if (w_Done_Rise)
                              w_Next_State = (r_Byte_Idx == LAST_IDX) ? ST_IDLE : ST_GAP;
            ST_GAP:       if (!i_Tx_Done && !i_Tx_Active) w_Next_State = ST_ISSUE;
            default:      w_Next_State = ST_IDLE;
        endcase
    end

    always_comb begin
        o_Tx_DV    = (r_State == ST_ISSUE);
        w_Pop      = (r_State == ST_LOAD);
        w_Shift_En = (r_State == ST_WAIT_DONE) && w_Done_Rise;
        o_Busy     = (r_State != ST_IDLE) || !w_Fifo_Empty;
    end

    // The outgoing byte always sits at the sending end of the shift register.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign o_Tx_Byte    = r_Shift[31:24];
            assign w_Shift_Next = {r_Shift[23:0], 8'h00};
        end else begin : g_lsb_first
            assign o_Tx_Byte    = r_Shift[7:0];
            assign w_Shift_Next = {8'h00, r_Shift[31:8]};
        end
    endgenerate

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_Done_Q   <= 1'b0;
            r_Shift    <= '0;
            r_Byte_Idx <= '0;
        end else begin
            r_Done_Q <= i_Tx_Done;
            if (w_Pop) begin
                r_Shift    <= w_Head;
                r_Byte_Idx <= '0;
            end else if (w_Shift_En) begin
                r_Shift    <= w_Shift_Next;
                r_Byte_Idx <= r_Byte_Idx + BYTE_IDX_W'(1);
            end
        end
    end

    assign o_Word_Ready = !w_Fifo_Full;
    assign o_Fifo_Count = w_Count;

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Directed bench: two feeders (MSB-first and LSB-first) each driven against a small transmitter model.
module tb_uart_tx_word_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_word_dv, a_ready, a_tx_dv, a_active, a_busy;
    logic [31:0] a_word;
    logic [7:0]  a_tx_byte;
    logic [2:0]  a_count;
    logic        a_done = 1'b0;

    logic        b_word_dv, b_ready, b_tx_dv, b_active, b_busy;
    logic [31:0] b_word;
    logic [7:0]  b_tx_byte;
    logic [2:0]  b_count;
    logic        b_done = 1'b0;

    uart_tx_word_feeder #(.FIFO_DEPTH(4), .ADDR_W(2), .MSB_FIRST(1)) dut_a (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Word_DV(a_word_dv), .i_Word(a_word),
        .o_Word_Ready(a_ready), .o_Tx_DV(a_tx_dv), .o_Tx_Byte(a_tx_byte),
        .i_Tx_Active(a_active), .i_Tx_Done(a_done), .o_Busy(a_busy), .o_Fifo_Count(a_count)
    );

    uart_tx_word_feeder #(.FIFO_DEPTH(4), .ADDR_W(2), .MSB_FIRST(0)) dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Word_DV(b_word_dv), .i_Word(b_word),
        .o_Word_Ready(b_ready), .o_Tx_DV(b_tx_dv), .o_Tx_Byte(b_tx_byte),
        .i_Tx_Active(b_active), .i_Tx_Done(b_done), .o_Busy(b_busy), .o_Fifo_Count(b_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter models: busy 3 cycles after each pulse, then done held for a programmable length.
    logic       a_stall = 1'b0;
    logic       a_act_int = 1'b0;
    int         a_done_len = 2;
    int         a_phase = 0;
    int         a_cnt = 0;
    logic [7:0] a_cap[$];
    assign a_active = a_stall | a_act_int;

    always @(negedge clk) begin
        if (a_tx_dv) begin
            chk("a_dv_while_active", 32'(a_active), 32'd0);
            a_cap.push_back(a_tx_byte);
            a_act_int = 1'b1; a_done = 1'b0; a_phase = 1; a_cnt = 3;
        end else if (a_phase == 1) begin
            a_cnt--;
            if (a_cnt == 0) begin a_act_int = 1'b0; a_done = 1'b1; a_phase = 2; a_cnt = a_done_len; end
        end else if (a_phase == 2) begin
            a_cnt--;
            if (a_cnt == 0) begin a_done = 1'b0; a_phase = 0; end
        end
    end

    logic       b_act_int = 1'b0;
    int         b_phase = 0;
    int         b_cnt = 0;
    logic [7:0] b_cap[$];
    assign b_active = b_act_int;

    always @(negedge clk) begin
        if (b_tx_dv) begin
            chk("b_dv_while_active", 32'(b_active), 32'd0);
            b_cap.push_back(b_tx_byte);
            b_act_int = 1'b1; b_done = 1'b0; b_phase = 1; b_cnt = 3;
        end else if (b_phase == 1) begin
            b_cnt--;
            if (b_cnt == 0) begin b_act_int = 1'b0; b_done = 1'b1; b_phase = 2; b_cnt = 2; end
        end else if (b_phase == 2) begin
            b_cnt--;
            if (b_cnt == 0) begin b_done = 1'b0; b_phase = 0; end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] w);
        a_word_dv = 1'b1; a_word = w;
        cyc();
        a_word_dv = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while ((a_busy || a_phase != 0) && n < 600) begin cyc(); n++; end
        chk(tag, 32'(n >= 600), 32'd0);
    endtask

    // Compare four captured bytes of transmitter A against a word, MSB first.
    task automatic chk_word_a(input string tag, input int base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] got;
            got = (a_cap.size() > base + k) ? a_cap[base + k] : 8'hxx;
            chk(tag, 32'(got), 32'(w[31 - 8*k -: 8]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_word_dv = 1'b0; a_word = '0;
        b_word_dv = 1'b0; b_word = '0;
        cyc(); cyc();

        chk("rst_tx_dv",   32'(a_tx_dv),   32'd0);
        chk("rst_tx_byte", 32'(a_tx_byte), 32'h00);
        chk("rst_busy",    32'(a_busy),    32'd0);
        chk("rst_ready",   32'(a_ready),   32'd1);
        chk("rst_count",   32'(a_count),   32'd0);
        rst_n = 1'b1;
        cyc();

        // Single word, MSB first, latency to first pulse
        a_cap.delete();
        push_a(32'hDEADBEEF);
        chk("t1_count_n1", 32'(a_count), 32'd1);
        chk("t1_dv_n1",    32'(a_tx_dv), 32'd0);
        cyc();
        chk("t1_dv_n2",    32'(a_tx_dv), 32'd0);
        cyc();
        chk("t1_dv_n3",    32'(a_tx_dv), 32'd1);
        chk("t1_byte0",    32'(a_tx_byte), 32'hDE);
        chk("t1_busy",     32'(a_busy), 32'd1);
        chk("t1_count_n3", 32'(a_count), 32'd0);
        wait_idle_a("t1_timeout");
        chk("t1_pulses", 32'(a_cap.size()), 32'd4);
        chk_word_a("t1_bytes", 0, 32'hDEADBEEF);
        chk("t1_busy_end", 32'(a_busy), 32'd0);

        // LSB-first instance
        b_cap.delete();
        b_word_dv = 1'b1; b_word = 32'h11223344;
        cyc();
        b_word_dv = 1'b0;
        for (int n = 0; n < 600 && (b_busy || b_phase != 0); n++) cyc();
        chk("t2_busy_end", 32'(b_busy), 32'd0);
        chk("t2_pulses", 32'(b_cap.size()), 32'd4);
        chk("t2_b0", 32'((b_cap.size() > 0) ? b_cap[0] : 8'hxx), 32'h44);
        chk("t2_b1", 32'((b_cap.size() > 1) ? b_cap[1] : 8'hxx), 32'h33);
        chk("t2_b2", 32'((b_cap.size() > 2) ? b_cap[2] : 8'hxx), 32'h22);
        chk("t2_b3", 32'((b_cap.size() > 3) ? b_cap[3] : 8'hxx), 32'h11);

        // FIFO full while transmitter is stalled busy
        a_cap.delete();
        a_stall = 1'b1;
        a_word_dv = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a_word = 32'(i);
            cyc();
            chk("t3_count", 32'(a_count), (i < 4) ? 32'(i) : 32'd4);
            chk("t3_ready", 32'(a_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        a_word_dv = 1'b0;
        cyc();
        chk("t3_no_dv_stalled", 32'(a_cap.size()), 32'd0);
        a_stall = 1'b0;
        wait_idle_a("t3_timeout");
        chk("t3_pulses", 32'(a_cap.size()), 32'd16);
        for (int i = 1; i <= 4; i++) chk_word_a("t3_bytes", 4*(i-1), 32'(i));
        chk("t3_count_end", 32'(a_count), 32'd0);

        // Done held 5 cycles per byte
        a_cap.delete();
        a_done_len = 5;
        push_a(32'h01020304);
        wait_idle_a("t4_timeout");
        chk("t4_pulses", 32'(a_cap.size()), 32'd4);
        chk_word_a("t4_bytes", 0, 32'h01020304);
        a_done_len = 2;

        // Push in the exact LOAD cycle with count = 1
        a_cap.delete();
        push_a(32'h0A0B0C0D);
        cyc();
        chk("t5_count_load", 32'(a_count), 32'd1);
        chk("t5_dv_load",    32'(a_tx_dv), 32'd0);
        a_word_dv = 1'b1; a_word = 32'h1A2B3C4D;
        cyc();
        a_word_dv = 1'b0;
        chk("t5_count_simul", 32'(a_count), 32'd1);
        chk("t5_dv_issue",    32'(a_tx_dv), 32'd1);
        wait_idle_a("t5_timeout");
        chk("t5_pulses", 32'(a_cap.size()), 32'd8);
        chk_word_a("t5_word0", 0, 32'h0A0B0C0D);
        chk_word_a("t5_word1", 4, 32'h1A2B3C4D);

        // Reset after the second byte of a word, with two words queued
        a_cap.delete();
        push_a(32'hCAFEF00D);
        push_a(32'h11111111);
        push_a(32'h22222222);
        begin
            int n = 0;
            while (a_cap.size() < 2 && n < 200) begin cyc(); n++; end
            chk("t6_wait_timeout", 32'(n >= 200), 32'd0);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t6_rst_dv",    32'(a_tx_dv),   32'd0);
        chk("t6_rst_byte",  32'(a_tx_byte), 32'h00);
        chk("t6_rst_busy",  32'(a_busy),    32'd0);
        chk("t6_rst_count", 32'(a_count),   32'd0);
        chk("t6_rst_ready", 32'(a_ready),   32'd1);
        chk("t6_pre_bytes", 32'(a_cap.size()), 32'd2);
        chk("t6_pre_b0", 32'((a_cap.size() > 0) ? a_cap[0] : 8'hxx), 32'hCA);
        chk("t6_pre_b1", 32'((a_cap.size() > 1) ? a_cap[1] : 8'hxx), 32'hFE);
        repeat (40) cyc();
        chk("t6_quiet", 32'(a_cap.size()), 32'd2);
        chk("t6_quiet_busy", 32'(a_busy), 32'd0);
        push_a(32'h55AA55AA);
        wait_idle_a("t6_timeout");
        chk("t6_pulses", 32'(a_cap.size()), 32'd6);
        chk_word_a("t6_new_word", 2, 32'h55AA55AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
